// File: rtl/button_autorepeat_pkg.sv
// Shared definitions for the button auto-repeat block: FSM state encoding
// and the elaboration-time parameter sanity check.
package button_autorepeat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    // Rejects zero parameters, a floor above the start period, and loads that do not fit CNT_W.
    function automatic bit paramsOk(input int firstDelay, input int startPeriod,
                                    input int minPeriod, input int accelSteps,
                                    input int cntW, input int lvlW);
        longint cap;
        cap = longint'(1) << cntW;
        return (firstDelay >= 1) && (minPeriod >= 1) && (accelSteps >= 1) &&
               (cntW >= 1) && (lvlW >= 1) && (minPeriod <= startPeriod) &&
               (longint'(firstDelay) < cap) && (longint'(startPeriod) < cap);
    endfunction

endpackage

// File: rtl/button_autorepeat_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, reset to a fixed value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_autorepeat.sv
// Turns a debounced button level into step pulses: one on press, then
// accelerating repeats while held, with the repeat period halving down to a floor.
module button_autorepeat
    import button_autorepeat_pkg::*;
#(
    parameter int FIRST_DELAY  = 2500000,
    parameter int START_PERIOD = 1000000,
    parameter int MIN_PERIOD   = 62500,
    parameter int ACCEL_STEPS  = 4,
    parameter int CNT_W        = 24,
    parameter int LVL_W        = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_i,
    output logic             step_o,
    output logic             held_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int               REP_W      = $clog2(ACCEL_STEPS + 1);
    localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] START_P    = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [REP_W-1:0] REP_MAX    = REP_W'(ACCEL_STEPS);

    generate
        if (!paramsOk(FIRST_DELAY, START_PERIOD, MIN_PERIOD, ACCEL_STEPS, CNT_W, LVL_W)) begin : gBadParams
            $error("button_autorepeat: illegal parameter set");
        end
    endgenerate

    logic btnSync;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b0)
    ) uSync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (btn_i),
        .q_o   (btnSync)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [REP_W-1:0] repCnt_q;
    logic [LVL_W-1:0] level_q;
    logic             step_q;
    logic             held_q;

    logic [CNT_W-1:0] periodHalf;
    logic [CNT_W-1:0] halvedPeriod;
    logic [REP_W-1:0] repNext;
    logic [LVL_W-1:0] levelNext;

    // repNext counts the step being issued, so the ACCEL_STEPS-th repeat at a period halves it.
    always_comb begin
        periodHalf   = period_q >> 1;
        halvedPeriod = (periodHalf < MIN_P) ? MIN_P : periodHalf;
        repNext      = (repCnt_q >= REP_MAX) ? REP_MAX : repCnt_q + REP_W'(1);
        levelNext    = (&level_q) ? level_q : level_q + LVL_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= START_P;
            repCnt_q <= '0;
            level_q  <= '0;
            step_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            held_q <= btnSync;
            case (state_q)
                IDLE: begin
                    if (btnSync) begin
                        step_q  <= 1'b1;
                        cnt_q   <= FIRST_LOAD;
                        state_q <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!btnSync) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        period_q <= START_P;
                        repCnt_q <= '0;
                        level_q  <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (state_q == DELAY) begin
                        step_q   <= 1'b1;
                        repCnt_q <= REP_W'(1);
                        cnt_q    <= period_q - CNT_W'(1);
                        state_q  <= REPEAT;
                    end else begin
                        step_q <= 1'b1;
                        if ((repNext == REP_MAX) && (period_q > MIN_P)) begin
                            period_q <= halvedPeriod;
                            level_q  <= levelNext;
                            repCnt_q <= '0;
                            cnt_q    <= halvedPeriod - CNT_W'(1);
                        end else begin
                            repCnt_q <= repNext;
                            cnt_q    <= period_q - CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign step_o  = step_q;
    assign held_o  = held_q;
    assign level_o = level_q;

endmodule

// File: tb/tb_button_autorepeat.sv
// Scoreboard bench for button_autorepeat: expected step cycles/levels are queued
// at press time and popped by a monitor whenever a DUT emits a step.
module tb_button_autorepeat;

    logic       clk = 1'b0;
    logic       rstN;
    logic       btnA;
    logic       btnB;
    logic       stepA;
    logic       heldA;
    logic [2:0] levelA;
    logic       stepB;
    logic       heldB;
    logic [0:0] levelB;

    int cyc     = 0;
    int nChecks = 0;
    int nFails  = 0;

    int expCycA[$];
    int expLvlA[$];
    int expCycB[$];
    int expLvlB[$];

    button_autorepeat #(
        .FIRST_DELAY (10),
        .START_PERIOD(8),
        .MIN_PERIOD  (2),
        .ACCEL_STEPS (2),
        .CNT_W       (8),
        .LVL_W       (3)
    ) dutA (
        .clk_i  (clk),
        .rst_ni (rstN),
        .btn_i  (btnA),
        .step_o (stepA),
        .held_o (heldA),
        .level_o(levelA)
    );

    button_autorepeat #(
        .FIRST_DELAY (10),
        .START_PERIOD(8),
        .MIN_PERIOD  (1),
        .ACCEL_STEPS (2),
        .CNT_W       (8),
        .LVL_W       (1)
    ) dutB (
        .clk_i  (clk),
        .rst_ni (rstN),
        .btn_i  (btnB),
        .step_o (stepB),
        .held_o (heldB),
        .level_o(levelB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every step pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        int c;
        int l;
        if (stepA) begin
            if (expCycA.size() == 0) begin
                checkOutput("stepA unexpected (cycle shown as got)", cyc, -1);
            end else begin
                c = expCycA.pop_front();
                l = expLvlA.pop_front();
                checkOutput("stepA cycle", cyc, c);
                checkOutput("stepA level", int'(levelA), l);
            end
        end
        if (stepB) begin
            if (expCycB.size() == 0) begin
                checkOutput("stepB unexpected (cycle shown as got)", cyc, -1);
            end else begin
                c = expCycB.pop_front();
                l = expLvlB.pop_front();
                checkOutput("stepB cycle", cyc, c);
                checkOutput("stepB level", int'(levelB), l);
            end
        end
    end

    // Press at a negedge, hold for 'hold' negedges; offsets are relative to the press step.
    task automatic applyStimulus(input bit selB, input int hold, input int offs[$], input int lvls[$]);
        int base;
        @(negedge clk);
        base = cyc + 3;
        foreach (offs[i]) begin
            if (selB) begin
                expCycB.push_back(base + offs[i]);
                expLvlB.push_back(lvls[i]);
            end else begin
                expCycA.push_back(base + offs[i]);
                expLvlA.push_back(lvls[i]);
            end
        end
        if (selB) btnB = 1'b1;
        else      btnA = 1'b1;
        repeat (hold) @(negedge clk);
        btnA = 1'b0;
        btnB = 1'b0;
    endtask

    initial begin : stimulus
        int offs[$];
        int lvls[$];
        int base;

        rstN = 1'b0;
        btnA = 1'b0;
        btnB = 1'b0;
        #1;
        checkOutput("reset stepA", int'(stepA), 0);
        checkOutput("reset heldA", int'(heldA), 0);
        checkOutput("reset levelA", int'(levelA), 0);
        checkOutput("reset levelB", int'(levelB), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] test 1: single tap");
        offs = '{0};
        lvls = '{0};
        applyStimulus(1'b0, 5, offs, lvls);
        repeat (20) @(negedge clk);

        $display("[TB] test 2: long hold");
        offs = '{0, 10, 18, 22, 26, 28, 30, 32, 34, 36, 38};
        lvls = '{0, 0, 1, 1, 2, 2, 2, 2, 2, 2, 2};
        applyStimulus(1'b0, 40, offs, lvls);
        checkOutput("hold levelA", int'(levelA), 2);
        checkOutput("hold heldA", int'(heldA), 1);
        repeat (5) @(negedge clk);
        checkOutput("release levelA", int'(levelA), 0);
        checkOutput("release heldA", int'(heldA), 0);
        repeat (15) @(negedge clk);

        $display("[TB] test 3: release before due step, then re-press");
        offs = '{0, 10};
        lvls = '{0, 0};
        applyStimulus(1'b0, 18, offs, lvls);
        offs = '{0, 10, 18};
        lvls = '{0, 0, 1};
        applyStimulus(1'b0, 19, offs, lvls);
        repeat (20) @(negedge clk);

        $display("[TB] test 4: reset mid-repeat");
        @(negedge clk);
        base = cyc + 3;
        offs = '{0, 10, 18, 22};
        lvls = '{0, 0, 1, 1};
        foreach (offs[i]) begin
            expCycA.push_back(base + offs[i]);
            expLvlA.push_back(lvls[i]);
        end
        btnA = 1'b1;
        repeat (27) @(negedge clk);
        checkOutput("pre-reset heldA", int'(heldA), 1);
        checkOutput("pre-reset levelA", int'(levelA), 1);
        rstN = 1'b0;
        #1;
        checkOutput("async reset stepA", int'(stepA), 0);
        checkOutput("async reset heldA", int'(heldA), 0);
        checkOutput("async reset levelA", int'(levelA), 0);
        @(negedge clk);
        rstN = 1'b1;
        expCycA.push_back(cyc + 3);
        expLvlA.push_back(0);
        repeat (5) @(negedge clk);
        btnA = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] test 5: saturation run on the fast instance");
        offs = '{0, 10, 18, 22, 26, 28, 30};
        lvls = '{0, 0, 1, 1, 1, 1, 1};
        for (int k = 31; k < 60; k++) begin
            offs.push_back(k);
            lvls.push_back(1);
        end
        applyStimulus(1'b1, 60, offs, lvls);
        checkOutput("saturated levelB", int'(levelB), 1);
        repeat (20) @(negedge clk);

        $display("[TB] test 6: glitchy button pulses");
        offs = '{0};
        lvls = '{0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1, offs, lvls);
            @(negedge clk);
        end
        repeat (20) @(negedge clk);

        checkOutput("leftover expected steps A", expCycA.size(), 0);
        checkOutput("leftover expected steps B", expCycB.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
